toggle_checker: RTL and testbench
=================================

Name: toggle_checker

Overview:
Synthesizable monitor for a free-running toggling signal, such as the clock-derived stream from the repeater/invertor chain.
- Measures the half-period of `in` in `clk` cycles.
- Declares lock after a run of on-spec half-periods.
- Flags period errors, a stuck input, and a broken complement relation between `in` and `inv_in`.
- Sits at the receiving end of a toggle source, on-chip or in a bench, and reports health through sticky flags.

Parameters:
- CNT_W, 8, width of the half-period counter and the `half_period` output.
- EXP_HALF, 4, expected half-period in `clk` cycles (1..2^CNT_W-2).
- TOL, 0, allowed deviation: measured value m is good iff |m-EXP_HALF| <= TOL.
- LOCK_CNT, 4, consecutive good half-periods required to lock (1..15).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous reset, active-high.
- in  input  1  monitored toggling signal.
- inv_in  input  1  signal expected to equal ~in every cycle.
- clr  input  1  synchronous clear of sticky flags and `edge_cnt`.
- locked  output  1  high while in LOCKED state.
- err_period  output  1  sticky: bad half-period measured while LOCKED.
- err_stuck  output  1  sticky: no edge for 2^CNT_W-1 cycles.
- err_inv  output  1  sticky: in == inv_in while not IDLE.
- half_period  output  CNT_W  last measured half-period.
- edge_cnt  output  16  edges seen since reset/clr, saturating at 16'hFFFF.

Behaviour:
- Reset (async, `rst`=1): all outputs 0, state IDLE, internal counters 0, sample flops 0.
- Sampling:
  - in_s/inv_s are the inputs registered once, or through the synchronizer (see Optional Feature).
  - in_p <= in_s every cycle.
  - edge = in_s != in_p.
- Cycle counter `cnt`:
  - Set to 1 on an edge, otherwise increments.
  - Saturates at 2^CNT_W-1.
- Measurement: on an edge outside IDLE, m = cnt.
  - `half_period` <= m.
  - A toggle every N clk cycles yields m = N.
  - `half_period` updates 1 cycle after the edge is detected, i.e. 2 cycles after `in` changes without the optional feature.
- `edge_cnt` increments on every edge, including the first edge out of IDLE.
- FSM, 2-bit, states IDLE / ACQUIRE / LOCKED:
  - IDLE: the first edge starts the counter and goes to ACQUIRE; no measurement is taken.
  - ACQUIRE:
    - Good m: good_cnt++. When good_cnt reaches LOCK_CNT, go to LOCKED and clear good_cnt.
    - Bad m: good_cnt = 0, stay in ACQUIRE, no error flag.
  - LOCKED:
    - Good m: stay.
    - Bad m: set `err_period`, go to ACQUIRE, good_cnt = 0.
  - Any non-IDLE state: if `cnt` hits saturation, set `err_stuck`, go to IDLE, good_cnt = 0.
- `locked` is a registered decode of state == LOCKED. It rises on the cycle after the LOCK_CNT-th good edge is detected.
- Inversion check: in any cycle with state != IDLE and in_s == inv_s, set `err_inv`.
- Sticky flags are cleared only by `rst` or `clr`.
- Simultaneous `clr` and a flag-set event in the same cycle: set wins (flag = 1).
- `clr` also zeroes `edge_cnt`. If an edge coincides with `clr`, `edge_cnt` = 1.
- `clr` never changes the FSM state, `half_period` or `locked`.
- Reset asserted mid-operation returns to the reset values immediately, regardless of `clk`.

Optional Feature:
- Macro: TOGGLE_CHECKER_SYNC_EN.
- Defined:
  - `in` and `inv_in` each pass through a 2-flop synchronizer before in_s/inv_s.
  - All detection latencies grow by 1 cycle: `half_period` updates 3 cycles after `in` changes.
  - Measured values are unchanged.
- Undefined: a single register stage, as described in Behaviour.

Test Plan:
1. Lock: `in` toggles every 4 clk, `inv_in` = ~`in`, defaults. Expected: `locked` rises after the 5th edge; `half_period`=4, `edge_cnt`=5 at lock; all err flags 0.
2. Period fault: after lock, stretch one half-period to 6 clk. Expected: `err_period`=1, `locked`=0, `half_period`=6; `locked` returns after 4 further 4-clk half-periods; `err_period` stays 1.
3. Tolerance: TOL=1, half-periods alternate 3/5. Expected: lock reached, `err_period`=0. With TOL=0 the same stimulus never locks and `err_period`=0.
4. Stuck input: after lock, hold `in` constant, CNT_W=4. Expected: `err_stuck`=1 when `cnt` hits 15, state IDLE, `locked`=0; the next toggles re-acquire.
5. Inversion: after lock, force `inv_in` = `in` for 1 cycle. Expected: `err_inv`=1 and stays 1; `locked` is unaffected.
6. Clear/reset: assert `clr` in the same cycle as a bad LOCKED edge. Expected: `err_period`=1 and `edge_cnt`=1. Assert `rst` asynchronously mid-period. Expected: all outputs 0 before the next `clk` edge.

Source files
------------

// File: rtl/toggle_checker.sv
// toggle_checker: measures the half-period of a toggling input, locks on a run of good periods, flags faults.
// Define TOGGLE_CHECKER_SYNC_EN to put a 2-flop synchronizer in front of the sampled inputs.
module toggle_checker #(
    parameter int CNT_W    = 8,
    parameter int EXP_HALF = 4,
    parameter int TOL      = 0,
    parameter int LOCK_CNT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in,
    input  logic             inv_in,
    input  logic             clr,
    output logic             locked,
    output logic             err_period,
    output logic             err_stuck,
    output logic             err_inv,
    output logic [CNT_W-1:0] half_period,
    output logic [15:0]      edge_cnt
);
    typedef enum logic [1:0] {IDLE, ACQUIRE, LOCKED} state_t;

    localparam logic [CNT_W:0] EXP_V     = (CNT_W+1)'(EXP_HALF);
    localparam logic [CNT_W:0] TOL_V     = (CNT_W+1)'(TOL);
    localparam logic [3:0]     LOCK_LAST = 4'(LOCK_CNT - 1);

    state_t           r_state, w_state_nx;
    logic             r_in_s, r_inv_s, r_in_p;
    logic [CNT_W-1:0] r_cnt, r_half;
    logic [3:0]       r_good, w_good_nx;
    logic [15:0]      r_edge_cnt;
    logic             r_locked, r_err_period, r_err_stuck, r_err_inv;
    logic             w_edge, w_good, w_sat, w_set_period, w_set_stuck, w_set_inv;
    logic [CNT_W:0]   w_m, w_diff;

`ifdef TOGGLE_CHECKER_SYNC_EN
    logic r_in_m, r_inv_m;
    always_ff @(posedge clk or posedge rst)
        if (rst) {r_in_m, r_inv_m, r_in_s, r_inv_s} <= '0;
        else     {r_in_m, r_inv_m, r_in_s, r_inv_s} <= {in, inv_in, r_in_m, r_inv_m};
`else
    always_ff @(posedge clk or posedge rst)
        if (rst) {r_in_s, r_inv_s} <= '0;
        else     {r_in_s, r_inv_s} <= {in, inv_in};
`endif

    assign w_edge    = r_in_s != r_in_p;
    assign w_sat     = r_cnt == '1;
    assign w_m       = {1'b0, r_cnt};
    assign w_diff    = (w_m > EXP_V) ? w_m - EXP_V : EXP_V - w_m;
    assign w_good    = w_diff <= TOL_V;
    assign w_set_inv = r_state != IDLE && r_in_s == r_inv_s;

    // An edge in the saturating cycle is still a measurement, so stuck only fires without one.
    always_comb begin
        w_state_nx   = r_state;
        w_good_nx    = r_good;
        w_set_period = 1'b0;
        w_set_stuck  = 1'b0;
        if (r_state != IDLE && !w_edge && w_sat) begin
            w_state_nx  = IDLE;
            w_good_nx   = '0;
            w_set_stuck = 1'b1;
        end else if (w_edge) begin
            case (r_state)
                IDLE: w_state_nx = ACQUIRE;
                ACQUIRE: begin
                    w_good_nx = (w_good && r_good != LOCK_LAST) ? r_good + 4'd1 : '0;
                    if (w_good && r_good == LOCK_LAST) w_state_nx = LOCKED;
                end
                LOCKED: begin
                    w_good_nx    = '0;
                    w_set_period = !w_good;
                    if (!w_good) w_state_nx = ACQUIRE;
                end
                default: w_state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            r_state      <= IDLE;
            r_good       <= '0;
            r_locked     <= 1'b0;
            r_in_p       <= 1'b0;
            r_cnt        <= '0;
            r_half       <= '0;
            r_err_period <= 1'b0;
            r_err_stuck  <= 1'b0;
            r_err_inv    <= 1'b0;
            r_edge_cnt   <= '0;
        end else begin
            r_state      <= w_state_nx;
            r_good       <= w_good_nx;
            r_locked     <= w_state_nx == LOCKED;
            r_in_p       <= r_in_s;
            r_cnt        <= w_edge ? CNT_W'(1) : (w_sat ? r_cnt : r_cnt + 1'b1);
            if (w_edge && r_state != IDLE) r_half <= r_cnt;
            r_err_period <= w_set_period || (r_err_period && !clr);
            r_err_stuck  <= w_set_stuck || (r_err_stuck && !clr);
            r_err_inv    <= w_set_inv || (r_err_inv && !clr);
            r_edge_cnt   <= clr ? 16'(w_edge) : r_edge_cnt + 16'(w_edge && r_edge_cnt != 16'hFFFF);
        end

    assign locked      = r_locked;
    assign err_period  = r_err_period;
    assign err_stuck   = r_err_stuck;
    assign err_inv     = r_err_inv;
    assign half_period = r_half;
    assign edge_cnt    = r_edge_cnt;
endmodule

// File: tb/tb_toggle_checker.sv
// tb_toggle_checker: vector table of half-period segments with a scoreboard, over three parameterisations.
module tb_toggle_checker;
    logic clk = 1'b0, rst = 1'b1, clr = 1'b0;
    logic in_a = 1'b0, inv_a = 1'b1, in_t = 1'b0, inv_t = 1'b1, in_s = 1'b0, inv_s = 1'b1;
    logic lk_a, ep_a, es_a, ei_a, lk_t, ep_t, es_t, ei_t, lk_s, ep_s, es_s, ei_s;
    logic [7:0] hp_a, hp_t;
    logic [3:0] hp_s;
    logic [15:0] ec_a, ec_t, ec_s;
    int errs = 0, checks = 0;

    always #5 clk = ~clk;

    toggle_checker u_a (.clk(clk), .rst(rst), .in(in_a), .inv_in(inv_a), .clr(clr), .locked(lk_a),
        .err_period(ep_a), .err_stuck(es_a), .err_inv(ei_a), .half_period(hp_a), .edge_cnt(ec_a));
    toggle_checker #(.TOL(1)) u_t (.clk(clk), .rst(rst), .in(in_t), .inv_in(inv_t), .clr(clr), .locked(lk_t),
        .err_period(ep_t), .err_stuck(es_t), .err_inv(ei_t), .half_period(hp_t), .edge_cnt(ec_t));
    toggle_checker #(.CNT_W(4)) u_s (.clk(clk), .rst(rst), .in(in_s), .inv_in(inv_s), .clr(clr), .locked(lk_s),
        .err_period(ep_s), .err_stuck(es_s), .err_inv(ei_s), .half_period(hp_s), .edge_cnt(ec_s));

    // en selects which instances toggle (1=a, 2=tol, 4=stuck); the highest enabled one is checked.
    typedef struct {
        logic [2:0]  en;
        int          n;
        logic        c, g, lk, ep, es, ei;
        logic [7:0]  hp;
        logic [15:0] ec;
    } vec_t;

    vec_t tab[$];
    vec_t sb[$];

    function automatic vec_t v(input int en, n, c, g, lk, ep, es, ei, hp, ec);
        vec_t r;
        r.en = 3'(en); r.n = n; r.c = c[0]; r.g = g[0];
        r.lk = lk[0]; r.ep = ep[0]; r.es = es[0]; r.ei = ei[0];
        r.hp = 8'(hp); r.ec = 16'(ec);
        return r;
    endfunction

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic compare(input vec_t e, input string tag);
        logic [27:0] o;
        o = e.en[2] ? {lk_s, ep_s, es_s, ei_s, 4'h0, hp_s, ec_s} :
            e.en[1] ? {lk_t, ep_t, es_t, ei_t, hp_t, ec_t} :
                      {lk_a, ep_a, es_a, ei_a, hp_a, ec_a};
        chk({tag, " locked"}, 16'(o[27]), 16'(e.lk));
        chk({tag, " err_period"}, 16'(o[26]), 16'(e.ep));
        chk({tag, " err_stuck"}, 16'(o[25]), 16'(e.es));
        chk({tag, " err_inv"}, 16'(o[24]), 16'(e.ei));
        chk({tag, " half_period"}, 16'(o[23:16]), 16'(e.hp));
        chk({tag, " edge_cnt"}, o[15:0], e.ec);
    endtask

    // One toggle followed by a hold of n clk cycles; the edge's effects show 2 cycles after the toggle.
    task automatic drive(input vec_t x, input string tag);
        vec_t e;
        if (x.en[0]) begin in_a = ~in_a; inv_a = ~in_a; end
        if (x.en[1]) begin in_t = ~in_t; inv_t = ~in_t; end
        if (x.en[2]) begin in_s = ~in_s; inv_s = ~in_s; end
        sb.push_back(x);
        @(posedge clk); #1 clr = x.c;
        @(posedge clk); #1 clr = 1'b0;
        if (x.g) inv_a = in_a;
        @(negedge clk);
        if (sb.size() == 0) begin
            errs++;
            $display("FAIL %s: scoreboard empty", tag);
        end else begin
            e = sb.pop_front();
            compare(e, tag);
        end
        @(posedge clk); #1 inv_a = ~in_a;
        repeat (x.n - 3) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    initial begin
        // default instance: lock, period fault, relock, inversion glitch, clr with bad edge
        tab.push_back(v(1, 4, 0, 0, 0, 0, 0, 0, 0, 1));
        tab.push_back(v(1, 4, 0, 0, 0, 0, 0, 0, 4, 2));
        tab.push_back(v(1, 4, 0, 0, 0, 0, 0, 0, 4, 3));
        tab.push_back(v(1, 4, 0, 0, 0, 0, 0, 0, 4, 4));
        tab.push_back(v(1, 6, 0, 0, 1, 0, 0, 0, 4, 5));
        tab.push_back(v(1, 4, 0, 0, 0, 1, 0, 0, 6, 6));
        tab.push_back(v(1, 4, 0, 0, 0, 1, 0, 0, 4, 7));
        tab.push_back(v(1, 4, 0, 0, 0, 1, 0, 0, 4, 8));
        tab.push_back(v(1, 4, 0, 0, 0, 1, 0, 0, 4, 9));
        tab.push_back(v(1, 4, 0, 1, 1, 1, 0, 0, 4, 10));
        tab.push_back(v(1, 6, 0, 0, 1, 1, 0, 1, 4, 11));
        tab.push_back(v(1, 4, 1, 0, 0, 1, 0, 0, 6, 1));
        // tolerance: 3/5 alternation into TOL=1 and TOL=0 instances together
        tab.push_back(v(3, 3, 0, 0, 0, 0, 0, 0, 0, 1));
        tab.push_back(v(3, 5, 0, 0, 0, 0, 0, 0, 3, 2));
        tab.push_back(v(3, 3, 0, 0, 0, 0, 0, 0, 5, 3));
        tab.push_back(v(3, 5, 0, 0, 0, 0, 0, 0, 3, 4));
        tab.push_back(v(3, 3, 0, 0, 1, 0, 0, 0, 5, 5));
        tab.push_back(v(3, 3, 0, 0, 1, 0, 0, 0, 3, 6));
        // CNT_W=4 instance: lock before stuck
        tab.push_back(v(4, 4, 0, 0, 0, 0, 0, 0, 0, 1));
        tab.push_back(v(4, 4, 0, 0, 0, 0, 0, 0, 4, 2));
        tab.push_back(v(4, 4, 0, 0, 0, 0, 0, 0, 4, 3));
        tab.push_back(v(4, 4, 0, 0, 0, 0, 0, 0, 4, 4));
        tab.push_back(v(4, 4, 0, 0, 1, 0, 0, 0, 4, 5));
        // CNT_W=4 instance: re-acquire after stuck
        tab.push_back(v(4, 4, 0, 0, 0, 0, 1, 0, 4, 6));
        tab.push_back(v(4, 4, 0, 0, 0, 0, 1, 0, 4, 7));
        tab.push_back(v(4, 4, 0, 0, 0, 0, 1, 0, 4, 8));
        tab.push_back(v(4, 4, 0, 0, 0, 0, 1, 0, 4, 9));
        tab.push_back(v(4, 4, 0, 0, 1, 0, 1, 0, 4, 10));

        #12 compare(v(1, 0, 0, 0, 0, 0, 0, 0, 0, 0), "in_reset");
        @(posedge clk); #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk) compare(v(1, 0, 0, 0, 0, 0, 0, 0, 0, 0), "after_reset");
        @(posedge clk); #1;

        for (int i = 0; i < 12; i++) drive(tab[i], $sformatf("a%0d", i));

        @(posedge clk); #3 rst = 1'b1;
        #1 compare(v(1, 0, 0, 0, 0, 0, 0, 0, 0, 0), "async_rst");
        in_a = 1'b0; inv_a = 1'b1; in_t = 1'b0; inv_t = 1'b1; in_s = 1'b0; inv_s = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 12; i < 18; i++) drive(tab[i], $sformatf("tol%0d", i - 12));
        compare(v(1, 0, 0, 0, 0, 0, 0, 0, 3, 6), "tol0_a");

        for (int i = 18; i < 23; i++) drive(tab[i], $sformatf("stk%0d", i - 18));
        repeat (12) @(posedge clk);
        @(negedge clk);
        chk("stuck_pre err_stuck", 16'(es_s), 16'd0);
        chk("stuck_pre locked", 16'(lk_s), 16'd1);
        @(negedge clk);
        chk("stuck err_stuck", 16'(es_s), 16'd1);
        chk("stuck locked", 16'(lk_s), 16'd0);
        chk("stuck err_period", 16'(ep_s), 16'd0);
        for (int i = 23; i < 28; i++) drive(tab[i], $sformatf("reacq%0d", i - 23));

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
